mult_share_arbiter: RTL and testbench

- Shares one combinational signed 32x32 multiplier (team's signedMult, 63-bit product) among NUM_REQ requesters, e.g. audio L/R gain and filter-tap engines.
- Round-robin arbitration with valid/ready request handshake.
- Operands are registered and the multiplier gets a programmable multi-cycle settle window.
- Product is returned with a one-hot requester tag.

---
 rtl/mult_share_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mult_share_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one signed 32x32 multiplier among NUM_REQ requesters.
// Define MULT_SAT_EN to add the saturated Q-format output on resp_sat.
module mult_share_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MULT_CYCLES = 2,
  parameter int unsigned FRAC_BITS   = 15
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic                   resp_valid,
  output logic [NUM_REQ-1:0]     resp_id,
  output logic [62:0]            resp_prod,
  output logic [31:0]            resp_sat,
  output logic                   busy
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..8");
  end
  if (MULT_CYCLES < 1) begin : g_bad_mult_cycles
    $error("MULT_CYCLES must be at least 1");
  end
  if (FRAC_BITS > 31) begin : g_bad_frac_bits
    $error("FRAC_BITS must be in 0..31");
  end

  typedef enum logic [1:0] {StIdle, StMult, StDone} state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic signed [31:0] a_q, a_d, b_q, b_d;
  logic [NUM_REQ-1:0] owner_q, owner_d;
  logic [NUM_REQ-1:0] resp_id_q, resp_id_d;
  logic [62:0]        resp_prod_q, resp_prod_d;

  logic               win_found;
  logic [IdxW-1:0]    win_idx;
  logic [IdxW-1:0]    cand_idx;
  int unsigned        cand;
  logic [NUM_REQ-1:0] grant_oh;
  logic [62:0]        prod_w;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand     = (32'(rr_ptr_q) + k) % NUM_REQ;
      cand_idx = IdxW'(cand);
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
    grant_oh = win_found ? (NUM_REQ'(1) << win_idx) : '0;
  end

`ifdef MULT_SAT_EN
  logic signed [63:0] prod_full;
  logic signed [63:0] prod_shr;
  logic [31:0]        sat_w;
  logic [31:0]        resp_sat_q, resp_sat_d;

  assign prod_full = a_q * b_q;
  assign prod_w    = prod_full[62:0];
  assign prod_shr  = prod_full >>> FRAC_BITS;

  // Full 64-bit product keeps the true sign, so 2^62 clamps high.
  always_comb begin
    if (prod_shr > 64'sh0000_0000_7FFF_FFFF) begin
      sat_w = 32'h7FFF_FFFF;
    end else if (prod_shr < -64'sh0000_0000_8000_0000) begin
      sat_w = 32'h8000_0000;
    end else begin
      sat_w = prod_shr[31:0];
    end
  end
  assign resp_sat = resp_sat_q;
`else
  assign prod_w   = a_q * b_q;
  assign resp_sat = '0;
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    owner_d     = owner_q;
    resp_id_d   = resp_id_q;
    resp_prod_d = resp_prod_q;
`ifdef MULT_SAT_EN
    resp_sat_d  = resp_sat_q;
`endif
    req_ready   = '0;
    unique case (state_q)
      StIdle: begin
        if (win_found && !Reset) begin
          req_ready = grant_oh;
          a_d       = req_a[32*win_idx +: 32];
          b_d       = req_b[32*win_idx +: 32];
          owner_d   = grant_oh;
          rr_ptr_d  = (win_idx == IdxW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          cnt_d     = CntW'(MULT_CYCLES - 1);
          state_d   = StMult;
        end
      end
      StMult: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          resp_prod_d = prod_w;
`ifdef MULT_SAT_EN
          resp_sat_d  = sat_w;
`endif
          resp_id_d   = owner_q;
          state_d     = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      owner_q     <= '0;
      resp_id_q   <= '0;
      resp_prod_q <= '0;
`ifdef MULT_SAT_EN
      resp_sat_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      owner_q     <= owner_d;
      resp_id_q   <= resp_id_d;
      resp_prod_q <= resp_prod_d;
`ifdef MULT_SAT_EN
      resp_sat_q  <= resp_sat_d;
`endif
    end
  end

  assign resp_valid = (state_q == StDone);
  assign resp_id    = resp_id_q;
  assign resp_prod  = resp_prod_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter (NUM_REQ=4, MULT_CYCLES=2, FRAC_BITS=15).
module tb_mult_share_arbiter;

  logic         Clk;
  logic         Reset;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic         resp_valid;
  logic [3:0]   resp_id;
  logic [62:0]  resp_prod;
  logic [31:0]  resp_sat;
  logic         busy;

  int vecs = 0;
  int errs = 0;

  mult_share_arbiter #(
    .NUM_REQ    (4),
    .MULT_CYCLES(2),
    .FRAC_BITS  (15)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .resp_valid(resp_valid),
    .resp_id   (resp_id),
    .resp_prod (resp_prod),
    .resp_sat  (resp_sat),
    .busy      (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    @(negedge Clk);
    Reset     = 1'b1;
    req_valid = '0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  // Drive one request and wait (bounded) for its response strobe.
  task automatic issue_and_wait(input int unsigned idx, input logic [31:0] a,
                                input logic [31:0] b, output bit got);
    @(negedge Clk);
    req_a[32*idx +: 32] = a;
    req_b[32*idx +: 32] = b;
    req_valid = 4'(1 << idx);
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge Clk);
      if (busy) req_valid = '0;
      if (resp_valid) got = 1'b1;
    end
  endtask

  task automatic test_reset;
    Reset     = 1'b1;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    @(negedge Clk);
    @(negedge Clk);
    vecs++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready);
    if (req_ready !== 4'b0000) errs++;
    vecs++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", resp_valid); end
    vecs++; if (resp_id !== 4'b0000) begin errs++; $display("FAIL reset_id: got %b want 0000", resp_id); end
    vecs++; if (resp_prod !== 63'h0) begin errs++; $display("FAIL reset_prod: got %h want 0", resp_prod); end
    vecs++; if (resp_sat !== 32'h0) begin errs++; $display("FAIL reset_sat: got %h want 0", resp_sat); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    req_valid = '0;
    Reset     = 1'b0;
  endtask

  task automatic test_single;
    do_reset();
    req_a[95:64] = 32'd3;
    req_b[95:64] = 32'hFFFF_FFFC;
    req_valid    = 4'b0100;
    #1;
    vecs++; if (req_ready !== 4'b0100) begin errs++; $display("FAIL single_grant: got %b want 0100", req_ready); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL single_idle_busy: got %b want 0", busy); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge Clk);
      vecs++;
      if (busy !== (k <= 3)) begin errs++; $display("FAIL single_busy c%0d: got %b want %b", k, busy, (k <= 3)); end
      vecs++;
      if (resp_valid !== (k == 3)) begin
        errs++; $display("FAIL single_valid c%0d: got %b want %b", k, resp_valid, (k == 3));
      end
      vecs++;
      if (req_ready !== 4'b0000) begin errs++; $display("FAIL single_ready c%0d: got %b want 0000", k, req_ready); end
      if (k == 3) begin
        vecs++; if (resp_id !== 4'b0100) begin errs++; $display("FAIL single_id: got %b want 0100", resp_id); end
        vecs++;
        if (resp_prod !== 63'h7FFF_FFFF_FFFF_FFF4) begin
          errs++; $display("FAIL single_prod: got %h want 7ffffffffffffff4", resp_prod);
        end
      end
      req_valid = '0;
    end
  endtask

  task automatic test_round_robin;
    int gcnt = 0;
    int rcnt = 0;
    logic [3:0] drop = '0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = 32'(i + 1);
      req_b[32*i +: 32] = 32'd10;
    end
    req_valid = 4'b1111;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc > 0) @(negedge Clk);
      req_valid = req_valid & ~drop;
      drop = '0;
      #1;
      if (req_ready !== 4'b0000) begin
        vecs++;
        if (req_ready !== 4'(1 << gcnt) || cyc != 4 * gcnt) begin
          errs++; $display("FAIL rr_grant%0d: got %b at c%0d want %b at c%0d",
                           gcnt, req_ready, cyc, 4'(1 << gcnt), 4 * gcnt);
        end
        drop = req_ready;
        gcnt++;
      end
      if (resp_valid === 1'b1) begin
        vecs++;
        if (resp_id !== 4'(1 << rcnt) || resp_prod !== 63'((rcnt + 1) * 10) || cyc != 4 * rcnt + 3) begin
          errs++; $display("FAIL rr_resp%0d: got id %b prod %h c%0d want id %b prod %h c%0d", rcnt,
                           resp_id, resp_prod, cyc, 4'(1 << rcnt), 63'((rcnt + 1) * 10), 4 * rcnt + 3);
        end
        rcnt++;
      end
    end
    vecs++; if (gcnt != 4) begin errs++; $display("FAIL rr_grant_count: got %0d want 4", gcnt); end
    vecs++; if (rcnt != 4) begin errs++; $display("FAIL rr_resp_count: got %0d want 4", rcnt); end
    @(negedge Clk);
    req_valid = 4'b1111;
    #1;
    vecs++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL rr_wrap: got %b want 0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_two_rotation;
    int gcnt = 0;
    do_reset();
    req_valid = 4'b0011;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc > 0) @(negedge Clk);
      #1;
      if (req_ready !== 4'b0000) begin
        vecs++;
        if (req_ready !== 4'(1 << (gcnt % 2)) || cyc != 4 * gcnt) begin
          errs++; $display("FAIL rot_grant%0d: got %b at c%0d want %b at c%0d",
                           gcnt, req_ready, cyc, 4'(1 << (gcnt % 2)), 4 * gcnt);
        end
        gcnt++;
      end
    end
    vecs++; if (gcnt != 4) begin errs++; $display("FAIL rot_grant_count: got %0d want 4", gcnt); end
    @(negedge Clk);
    req_valid = '0;
    @(negedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_edge_operands;
    int unsigned   ti[3] = '{0, 3, 2};
    logic [31:0]   ta[3] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
    logic [31:0]   tb[3] = '{32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFB};
    logic [62:0]   tp[3] = '{63'h7FFF_FFFF_8000_0000, 63'h4000_0000_0000_0000, 63'h0};
    bit got;
    for (int v = 0; v < 3; v++) begin
      issue_and_wait(ti[v], ta[v], tb[v], got);
      vecs++; if (!got) begin errs++; $display("FAIL edge%0d_timeout: got no resp_valid want resp_valid", v); end
      vecs++;
      if (resp_prod !== tp[v]) begin errs++; $display("FAIL edge%0d_prod: got %h want %h", v, resp_prod, tp[v]); end
      vecs++;
      if (resp_id !== 4'(1 << ti[v])) begin
        errs++; $display("FAIL edge%0d_id: got %b want %b", v, resp_id, 4'(1 << ti[v]));
      end
    end
  endtask

  task automatic test_sat;
    bit got;
`ifdef MULT_SAT_EN
    logic [31:0] ta[4] = '{32'h0001_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [31:0] tb[4] = '{32'h0001_0000, 32'h7FFF_FFFF, 32'h8000_0001, 32'h8000_0000};
    logic [31:0] ts[4] = '{32'h0002_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    for (int v = 0; v < 4; v++) begin
      issue_and_wait(1, ta[v], tb[v], got);
      vecs++; if (!got) begin errs++; $display("FAIL sat%0d_timeout: got no resp_valid want resp_valid", v); end
      vecs++;
      if (resp_sat !== ts[v]) begin errs++; $display("FAIL sat%0d: got %h want %h", v, resp_sat, ts[v]); end
    end
`else
    issue_and_wait(1, 32'h0001_0000, 32'h0001_0000, got);
    vecs++; if (!got) begin errs++; $display("FAIL sat_timeout: got no resp_valid want resp_valid"); end
    vecs++; if (resp_sat !== 32'h0) begin errs++; $display("FAIL sat_off: got %h want 0", resp_sat); end
    vecs++;
    if (resp_prod !== 63'h0000_0001_0000_0000) begin
      errs++; $display("FAIL sat_off_prod: got %h want 100000000", resp_prod);
    end
`endif
  endtask

  task automatic test_reset_midop;
    bit seen = 1'b0;
    do_reset();
    req_a[63:32] = 32'd7;
    req_b[63:32] = 32'd9;
    req_valid    = 4'b0010;
    #1;
    vecs++; if (req_ready !== 4'b0010) begin errs++; $display("FAIL mid_grant: got %b want 0010", req_ready); end
    @(negedge Clk);
    req_valid = '0;
    Reset     = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_busy: got %b want 0", busy); end
    vecs++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL mid_valid: got %b want 0", resp_valid); end
    vecs++; if (resp_id !== 4'b0000) begin errs++; $display("FAIL mid_id: got %b want 0000", resp_id); end
    vecs++; if (resp_prod !== 63'h0) begin errs++; $display("FAIL mid_prod: got %h want 0", resp_prod); end
    vecs++; if (resp_sat !== 32'h0) begin errs++; $display("FAIL mid_sat: got %h want 0", resp_sat); end
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      if (resp_valid === 1'b1) seen = 1'b1;
    end
    vecs++; if (seen) begin errs++; $display("FAIL mid_dropped: got resp_valid want none"); end
    req_valid = 4'b1111;
    #1;
    vecs++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL mid_rr_restart: got %b want 0001", req_ready); end
    req_valid = '0;
  endtask

  initial begin
    Reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_two_rotation();
    test_edge_operands();
    test_sat();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
